// File: rtl/instr_fetch.sv
// Single-stage instruction fetch: PC register, one-cycle registered fetch from a
// combinational ROM, branch redirect, sticky bounds/alignment fault.
module instr_fetch #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_fault,
  output logic [31:0] fetch_count,
  output logic [1:0]  state
);

  // Handshake: none. The stage advances on every posedge unless stall=1;
  // branch_taken wins over stall, and a pending fault wins over both.

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [63:0] LAST_WORD = 64'(MEM_SIZE) - 64'd4;

  state_t      st;
  logic [63:0] pc;
  logic        bad_pc;

  // For an aligned PC, "PC + 3 >= MEM_SIZE" is the same as "PC > MEM_SIZE - 4",
  // and this form cannot wrap near 2^64.
  assign bad_pc    = (pc[1:0] != 2'b00) || (pc > LAST_WORD);
  assign imem_addr = pc;
  assign state     = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= FIRST;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= 64'h0;
      if_instr    <= 32'h0;
      fetch_fault <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      unique case (st)
        FIRST, RUN: begin
          if (bad_pc) begin
            st          <= FAULT;
            fetch_fault <= 1'b1;
            if_valid    <= 1'b0;
          end else if (branch_taken) begin
            st       <= RUN;
            pc       <= branch_target;
            if_valid <= 1'b0;
          end else if (!stall) begin
            if (st == FIRST) begin
              st <= RUN;
            end else begin
              if_instr <= imem_instr;
              if_pc    <= pc;
              if_valid <= 1'b1;
              pc       <= pc + 64'd4;
              if (fetch_count != 32'hFFFF_FFFF) begin
                fetch_count <= fetch_count + 32'd1;
              end
            end
          end
        end
        default: begin
          // FAULT is terminal until reset; everything stays frozen.
          st       <= FAULT;
          if_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random stall/branch traffic,
// checked every cycle against a behavioural fetch model.
module tb_instr_fetch;

  localparam int unsigned MEM_SIZE = 1024;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_fault;
  logic [31:0] fetch_count;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  // Model state: mode 0 = waiting for first edge, 1 = fetching, 2 = faulted.
  logic [63:0] m_pc;
  int          m_mode;
  logic        m_valid;
  logic [63:0] m_ipc;
  logic [31:0] m_instr;
  logic        m_fault;
  logic [31:0] m_count;

  instr_fetch #(.MEM_SIZE(MEM_SIZE), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .fetch_fault  (fetch_fault),
    .fetch_count  (fetch_count),
    .state        (state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word n holds 32'h100 + n.
  function automatic logic [31:0] rom(input logic [63:0] a);
    return 32'h100 + a[33:2];
  endfunction

  assign imem_instr = rom(imem_addr);

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_eq("imem_addr",   imem_addr,   m_pc);
    check_eq("if_valid",    {63'h0, if_valid},    {63'h0, m_valid});
    check_eq("fetch_fault", {63'h0, fetch_fault}, {63'h0, m_fault});
    check_eq("fetch_count", {32'h0, fetch_count}, {32'h0, m_count});
    check_eq("state",       {62'h0, state},       64'(m_mode));
    if (m_valid) begin
      check_eq("if_pc",    if_pc,    m_ipc);
      check_eq("if_instr", {32'h0, if_instr}, {32'h0, m_instr});
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_pc    = RESET_PC;
    m_mode  = 0;
    m_valid = 1'b0;
    m_ipc   = 64'h0;
    m_instr = 32'h0;
    m_fault = 1'b0;
    m_count = 32'h0;
  endtask

  task automatic model_edge(input logic s, input logic b, input logic [63:0] t);
    logic [64:0] top_byte;
    top_byte = {1'b0, m_pc} + 65'd3;
    if (m_mode == 2) return;
    if ((m_pc % 4) != 0 || top_byte >= 65'(MEM_SIZE)) begin
      m_mode  = 2;
      m_fault = 1'b1;
      m_valid = 1'b0;
    end else if (b) begin
      m_mode  = 1;
      m_pc    = t;
      m_valid = 1'b0;
    end else if (!s) begin
      if (m_mode == 0) begin
        m_mode = 1;
      end else begin
        m_ipc   = m_pc;
        m_instr = rom(m_pc);
        m_valid = 1'b1;
        m_pc    = m_pc + 64'd4;
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step(input logic s, input logic b, input logic [63:0] t);
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    @(posedge clk);
    model_edge(s, b, t);
    #1;
    check_all();
  endtask

  // Asserts reset away from any edge and checks it acts with no clock.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("rst_if_pc",    if_pc,    64'h0);
    check_eq("rst_if_instr", {32'h0, if_instr}, 64'h0);
    stall         = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 64'h80;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    branch_taken = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        s, b;
    logic [63:0] t;
    reset         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 64'h0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Sequential fetch, stall hold, branch over stall.
    step(0, 0, 64'h0);
    check_eq("first_edge_no_valid", {63'h0, if_valid}, 64'h0);
    step(0, 0, 64'h0);
    step(0, 0, 64'h0);
    check_eq("seq_if_pc", if_pc, 64'h4);
    repeat (3) step(1, 0, 64'h0);
    check_eq("stall_addr", imem_addr, 64'h8);
    check_eq("stall_if_pc", if_pc, 64'h4);
    step(0, 0, 64'h0);
    check_eq("seq_instr", {32'h0, if_instr}, 64'h102);
    check_eq("seq_count", {32'h0, fetch_count}, 64'd3);
    step(1, 1, 64'h40);
    check_eq("br_addr", imem_addr, 64'h40);
    step(0, 0, 64'h0);
    check_eq("br_if_pc", if_pc, 64'h40);

    // Last legal word, then out-of-bounds fault.
    step(0, 1, 64'h3FC);
    step(0, 0, 64'h0);
    check_eq("last_word_pc", if_pc, 64'h3FC);
    step(1, 0, 64'h0);
    check_eq("oob_fault", {63'h0, fetch_fault}, 64'h1);
    check_eq("oob_pc", imem_addr, 64'h400);
    step(0, 1, 64'h10);
    check_eq("fault_frozen_pc", imem_addr, 64'h400);
    do_reset();

    // Misaligned redirect faults; later branches are ignored.
    step(0, 0, 64'h0);
    step(0, 1, 64'h42);
    step(0, 1, 64'h8);
    check_eq("mis_fault", {63'h0, fetch_fault}, 64'h1);
    check_eq("mis_pc", imem_addr, 64'h42);
    step(0, 1, 64'h0);
    check_eq("mis_pc_held", imem_addr, 64'h42);
    do_reset();
    step(0, 0, 64'h0);
    step(0, 0, 64'h0);
    check_eq("resume_instr", {32'h0, if_instr}, 64'h100);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 9) == 0)
        t = {54'h0, 10'($urandom_range(0, 1023))} + (($urandom_range(0, 3) == 0) ? 64'h400 : 64'h0);
      else
        t = {52'h0, 10'($urandom_range(0, 255)), 2'b00};
      step(s, b, t);
      if ((m_mode == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
        do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
